// File: rtl/inst_rom_sync.sv
// inst_rom_sync: run-time-loadable instruction memory for the fetch stage.
// Registered read with one cycle of latency. Stall, flush and program-load
// port. After reset the array is scrubbed to NOP_VAL one word per cycle
// (CLEAR) before fetches are accepted (RUN). Misaligned or out-of-range
// fetch addresses return NOP_VAL with addr_err set.
// Optional build macro INST_ROM_PARITY_EN adds an even-parity bit per word
// and reports mismatches on par_err; without it par_err is tied low.
module inst_rom_sync #(
  parameter int                ADDR_W  = 5,
  parameter int                DATA_W  = 32,
  parameter int                PC_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   pc,
  input  logic              req,
  input  logic              stall,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              ready,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              addr_err,
  output logic              par_err
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef INST_ROM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE_IDX  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Stored word layout: parity bit (when enabled) above the data bits.
  function automatic logic [MEM_W-1:0] encode_word(input logic [DATA_W-1:0] d);
`ifdef INST_ROM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

`ifdef INST_ROM_PARITY_EN
  // True when the stored parity bit disagrees with the stored data bits.
  function automatic logic parity_bad(input logic [MEM_W-1:0] w);
    return w[DATA_W] ^ (^w[DATA_W-1:0]);
  endfunction
`endif

  state_t              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   clr_cnt_r, clr_cnt_nxt_s;
  logic [MEM_W-1:0]    mem_r [DEPTH];

  logic                we_s;
  logic [ADDR_W-1:0]   waddr_s;
  logic [MEM_W-1:0]    wdata_s;

  logic [PC_W-1:0]     pc_hi_s;
  logic                misaligned_s, out_of_range_s, err_s, accept_s;
  logic [ADDR_W-1:0]   idx_s;
  logic [MEM_W-1:0]    rdata_s;

  logic [DATA_W-1:0]   inst_r, inst_nxt_s;
  logic                inst_valid_r, inst_valid_nxt_s;
  logic                addr_err_r, addr_err_nxt_s;
  logic                par_err_nxt_s;

  // Address decode: bits above the array span mean the pc is out of range.
  assign pc_hi_s        = pc >> (ADDR_W + 2);
  assign misaligned_s   = (pc[1:0] != 2'b00);
  assign out_of_range_s = (pc_hi_s != '0);
  assign err_s          = misaligned_s | out_of_range_s;
  assign idx_s          = pc[ADDR_W+1:2];
  assign rdata_s        = mem_r[idx_s];

  assign ready    = (state_r == RUN) & ~prog_we;
  assign accept_s = req & ready & ~stall & ~flush;

  // State and clear-counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= CLEAR;
      clr_cnt_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      clr_cnt_r <= clr_cnt_nxt_s;
    end
  end

  // Next state: CLEAR walks every word once, then RUN forever.
  always_comb begin
    state_nxt_s   = state_r;
    clr_cnt_nxt_s = clr_cnt_r;
    case (state_r)
      CLEAR: begin
        clr_cnt_nxt_s = clr_cnt_r + ONE_IDX;
        if (clr_cnt_r == LAST_IDX) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      RUN: begin
        state_nxt_s = RUN;
      end
      default: begin
        state_nxt_s   = CLEAR;
        clr_cnt_nxt_s = '0;
      end
    endcase
  end

  // Single write port shared by the scrub walk and the program-load port.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = clr_cnt_r;
    wdata_s = encode_word(NOP_VAL);
    case (state_r)
      CLEAR: begin
        we_s = rst_n;
      end
      RUN: begin
        if (prog_we) begin
          we_s    = rst_n;
          waddr_s = prog_addr;
          wdata_s = encode_word(prog_data);
        end else begin
          we_s = 1'b0;
        end
      end
      default: begin
        we_s = 1'b0;
      end
    endcase
  end

  // Memory array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end
  end

  // Next fetch result, priority flush > stall > accept > idle bubble.
  always_comb begin
    inst_nxt_s       = inst_r;
    inst_valid_nxt_s = inst_valid_r;
    addr_err_nxt_s   = addr_err_r;
    par_err_nxt_s    = par_err;
    if (state_r != RUN) begin
      inst_nxt_s       = NOP_VAL;
      inst_valid_nxt_s = 1'b0;
      addr_err_nxt_s   = 1'b0;
      par_err_nxt_s    = 1'b0;
    end else if (flush) begin
      inst_nxt_s       = NOP_VAL;
      inst_valid_nxt_s = 1'b0;
      addr_err_nxt_s   = 1'b0;
      par_err_nxt_s    = 1'b0;
    end else if (stall) begin
      inst_nxt_s       = inst_r;
      inst_valid_nxt_s = inst_valid_r;
      addr_err_nxt_s   = addr_err_r;
      par_err_nxt_s    = par_err;
    end else if (accept_s && !err_s) begin
      inst_nxt_s       = rdata_s[DATA_W-1:0];
      inst_valid_nxt_s = 1'b1;
      addr_err_nxt_s   = 1'b0;
`ifdef INST_ROM_PARITY_EN
      par_err_nxt_s    = parity_bad(rdata_s);
`else
      par_err_nxt_s    = 1'b0;
`endif
    end else if (accept_s) begin
      inst_nxt_s       = NOP_VAL;
      inst_valid_nxt_s = 1'b1;
      addr_err_nxt_s   = 1'b1;
      par_err_nxt_s    = 1'b0;
    end else begin
      inst_nxt_s       = NOP_VAL;
      inst_valid_nxt_s = 1'b0;
      addr_err_nxt_s   = 1'b0;
      par_err_nxt_s    = 1'b0;
    end
  end

  // Registered fetch outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_r       <= NOP_VAL;
      inst_valid_r <= 1'b0;
      addr_err_r   <= 1'b0;
    end else begin
      inst_r       <= inst_nxt_s;
      inst_valid_r <= inst_valid_nxt_s;
      addr_err_r   <= addr_err_nxt_s;
    end
  end

`ifdef INST_ROM_PARITY_EN
  // Parity error flag registered alongside the fetched word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else begin
      par_err <= par_err_nxt_s;
    end
  end
`else
  assign par_err = 1'b0;
`endif

  assign inst       = inst_r;
  assign inst_valid = inst_valid_r;
  assign addr_err   = addr_err_r;

endmodule

// File: doc/inst_rom_sync.md
Name: inst_rom_sync

Overview:
Parametrised, synchronous, run-time-loadable instruction memory for the pipelined CPU fetch stage. Replaces the fixed 32-word combinational ROM.
- Registered read, 1-cycle latency.
- Stall, flush and program-load port.
- Self-clears to NOP after reset.
- Flags misaligned and out-of-range fetch addresses.

Parameters:
ADDR_W, 5, word-index width; DEPTH = 2**ADDR_W words
DATA_W, 32, instruction width
PC_W, 32, pc width; pc is a byte address, word index = pc[ADDR_W+1:2]
NOP_VAL, 32'h00000000, value returned for cleared, flushed, idle or erroneous fetches

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
pc  in  PC_W  fetch byte address
req  in  1  fetch request
stall  in  1  hold outputs, no new fetch accepted
flush  in  1  kill output, insert bubble
prog_we  in  1  program-load write strobe
prog_addr  in  ADDR_W  program-load word index
prog_data  in  DATA_W  program-load word
ready  out  1  fetch can be accepted this cycle
inst  out  DATA_W  fetched instruction (registered)
inst_valid  out  1  inst holds a valid fetch result
addr_err  out  1  registered with inst: misaligned or out-of-range pc
par_err  out  1  parity mismatch on fetched word (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - inst=NOP_VAL; inst_valid=0, addr_err=0, par_err=0, ready=0.
  - FSM goes to CLEAR; clear counter clr_cnt=0.
  - The memory array itself is not reset.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle writes mem[clr_cnt] <= NOP_VAL and increments clr_cnt.
  - The cycle that writes clr_cnt==DEPTH-1 transitions to RUN, so RUN is reached exactly DEPTH cycles after rst_n rises.
  - ready=0. req and prog_we are ignored. Outputs hold reset values.
  - Reset asserted mid-CLEAR restarts at clr_cnt=0.
- RUN:
  - ready = ~prog_we.
  - Accept condition: accept = req & ready & ~stall & ~flush.
  - Address checks:
    - misaligned = pc[1:0]!=0
    - out_of_range = (PC_W > ADDR_W+2) and pc[PC_W-1:ADDR_W+2]!=0
    - err = misaligned | out_of_range
  - Next-cycle output priority:
    1. flush: inst=NOP_VAL, inst_valid=0, addr_err=0, par_err=0. Overrides stall and accept.
    2. stall: inst, inst_valid, addr_err, par_err all hold.
    3. accept and err=0: inst=mem[pc[ADDR_W+1:2]], inst_valid=1, addr_err=0.
    4. accept and err=1: inst=NOP_VAL, inst_valid=1, addr_err=1. The array is not read.
    5. otherwise (no req, or prog_we): inst=NOP_VAL, inst_valid=0, addr_err=0.
- Program load:
  - prog_we in RUN writes mem[prog_addr] <= prog_data.
  - A write blocks a fetch in the same cycle (ready=0), so no read/write collision occurs.
  - A fetch of that word on the next cycle returns the new data.
  - prog_we=1 with stall=1: the write still occurs and outputs hold.
- Width rules: inst is exactly DATA_W bits. No sign or zero extension. No wrap-around of an out-of-range pc into the array.

Optional Feature:
INST_ROM_PARITY_EN:
- Defined:
  - The array is DATA_W+1 bits wide. Bit DATA_W holds even parity (XOR of the data bits), written by both CLEAR and prog_we.
  - On an accepted in-range fetch, parity is recomputed. On mismatch, par_err=1 with inst_valid=1 and inst delivered unchanged.
  - par_err follows the same flush/stall/hold rules as addr_err.
- Undefined: the array is DATA_W bits and par_err is tied to 0.

Test Plan:
- Clear sequence: rst_n low 2 cycles, then high. ready must stay 0 for exactly 32 cycles (ADDR_W=5), then go 1. A fetch of pc=0x7C then gives inst=0x00000000, inst_valid=1.
- Load and fetch: prog_we with prog_addr=1, prog_data=0x00430820 (ready=0 that cycle). Next cycle req with pc=0x4. One cycle later inst=0x00430820, inst_valid=1, addr_err=0.
- Stall hold and flush priority: fetch pc=0x4, then stall=1 for 3 cycles with pc changed to 0x8. inst must stay 0x00430820 and inst_valid=1. Then stall=1 and flush=1 together: next cycle inst=0, inst_valid=0.
- Address errors:
  - pc=0x6 gives inst=0, inst_valid=1, addr_err=1.
  - pc=0x80 gives addr_err=1.
  - pc=0x7C gives addr_err=0.
- Reset mid-operation: assert rst_n=0 during CLEAR at clr_cnt=10, and again in RUN with inst_valid=1. Next cycle all outputs are at reset values, and the full 32-cycle CLEAR reruns.
- Parity (INST_ROM_PARITY_EN defined): load 0xFFFFFFFF and 0x00000001, then fetch both: par_err=0. Without the macro, par_err is constant 0 throughout.
